// File: rtl/aes_byte_rx.sv
`default_nettype none
// ============================================================================
// Module      : aes_byte_rx
// Description : Byte-to-word deserializer for the 8-bit port receive path.
//               Reassembles four phase-tagged bytes (MSB first) into a
//               32-bit word, writes it to the AES input FIFO, flags framing
//               errors and dropped words, and keeps a saturating error count.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_byte_rx #(
    parameter int IN_REG = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx,
    input  logic        shakehand,
    input  logic        full,
    input  logic        clr,
    output logic [31:0] data,
    output logic        wr,
    output logic        frame_err,
    output logic        overflow,
    output logic [7:0]  err_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_B1   = 2'd1,
        S_B2   = 2'd2,
        S_B3   = 2'd3
    } state_t;

    // Sampled byte and phase used by the decoder
    logic [7:0] w_b;
    logic       w_s;

    generate
        if (IN_REG != 0) begin : g_in_reg
            logic [7:0] r_rx_q;
            logic       r_sh_q;

            // Input register; phase resets to idle level so reset never looks like byte0
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rx_q <= 8'h00;
                    r_sh_q <= 1'b1;
                end else begin
                    r_rx_q <= rx;
                    r_sh_q <= shakehand;
                end
            end

            assign w_b = r_rx_q;
            assign w_s = r_sh_q;
        end else begin : g_no_in_reg
            assign w_b = rx;
            assign w_s = shakehand;
        end
    endgenerate

    state_t      r_state;
    logic [23:0] r_word;      // bytes 0..2 of the word in progress
    logic [31:0] r_data;
    logic        r_wr;
    logic        r_frame_err;
    logic        r_overflow;
    logic [7:0]  r_err_cnt;

    logic w_exp_s;
    logic w_frame_evt;
    logic w_done;
    logic w_drop;
    logic w_err_evt;

    // Phase expected for the byte the current state is waiting on
    always_comb begin
        w_exp_s = 1'b0;
        case (r_state)
            S_B1:    w_exp_s = 1'b1;
            S_B2:    w_exp_s = 1'b0;
            S_B3:    w_exp_s = 1'b1;
            default: w_exp_s = 1'b0;
        endcase
    end

    assign w_frame_evt = (r_state != S_IDLE) && (w_s != w_exp_s);
    assign w_done      = (r_state == S_B3) && w_s;
    assign w_drop      = w_done && full;
    // Framing errors and drops are mutually exclusive on any given edge
    assign w_err_evt   = w_frame_evt | w_drop;

    // Word assembly state machine with registered write strobe and error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_word      <= 24'h000000;
            r_data      <= 32'h00000000;
            r_wr        <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_wr        <= 1'b0;
            r_frame_err <= w_frame_evt;
            if (w_frame_evt) begin
                // Drop the partial word; a phase-0 byte restarts a new word at once
                if (!w_s) begin
                    r_word  <= {w_b, 16'h0000};
                    r_state <= S_B1;
                end else begin
                    r_word  <= 24'h000000;
                    r_state <= S_IDLE;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (!w_s) begin
                            r_word[23:16] <= w_b;
                            r_state       <= S_B1;
                        end
                    end
                    S_B1: begin
                        r_word[15:8] <= w_b;
                        r_state      <= S_B2;
                    end
                    S_B2: begin
                        r_word[7:0] <= w_b;
                        r_state     <= S_B3;
                    end
                    S_B3: begin
                        r_state <= S_IDLE;
                        r_word  <= 24'h000000;
                        if (!full) begin
                            r_data <= {r_word, w_b};
                            r_wr   <= 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Sticky overflow and saturating error counter; a same-edge event beats clr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
            r_err_cnt  <= 8'h00;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr) begin
                r_overflow <= 1'b0;
            end

            if (w_err_evt) begin
                if (clr) begin
                    r_err_cnt <= 8'd1;
                end else if (r_err_cnt != 8'hFF) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
            end else if (clr) begin
                r_err_cnt <= 8'h00;
            end
        end
    end

    assign data      = r_data;
    assign wr        = r_wr;
    assign frame_err = r_frame_err;
    assign overflow  = r_overflow;
    assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_aes_byte_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_byte_rx
// Description : Directed testbench for aes_byte_rx, both input-register
//               options driven from one shared stimulus stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_byte_rx;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx;
    logic        shakehand;
    logic        full;
    logic        clr;

    logic [31:0] data0, data1;
    logic        wr0, wr1;
    logic        fe0, fe1;
    logic        ov0, ov1;
    logic [7:0]  ec0, ec1;

    int n_assert;
    int n_fail;
    int wr0_cnt;
    int fe0_cnt;
    int fe1_cnt;
    int wr_base;
    int fe_base;

    aes_byte_rx #(.IN_REG(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .rx(rx), .shakehand(shakehand),
        .full(full), .clr(clr), .data(data0), .wr(wr0),
        .frame_err(fe0), .overflow(ov0), .err_cnt(ec0)
    );

    aes_byte_rx #(.IN_REG(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .rx(rx), .shakehand(shakehand),
        .full(full), .clr(clr), .data(data1), .wr(wr1),
        .frame_err(fe1), .overflow(ov1), .err_cnt(ec1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters, sampled on the edge that ends each pulse
    always @(posedge clk) begin
        if (wr0 === 1'b1) wr0_cnt++;
        if (fe0 === 1'b1) fe0_cnt++;
        if (fe1 === 1'b1) fe1_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one byte for one cycle, then stop at mid-cycle to observe
    task automatic cyc(input logic [7:0] b, input logic s, input logic f, input logic c);
        @(posedge clk);
        #1;
        rx        = b;
        shakehand = s;
        full      = f;
        clr       = c;
        @(negedge clk);
    endtask

    initial begin
        n_assert = 0; n_fail = 0;
        wr0_cnt = 0; fe0_cnt = 0; fe1_cnt = 0;
        rst_n = 1'b0; rx = 8'h00; shakehand = 1'b1; full = 1'b0; clr = 1'b0;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        chk("rst_data",   data0, 32'h0);
        chk("rst_wr",     {31'h0, wr0}, 32'h0);
        chk("rst_fe",     {31'h0, fe0}, 32'h0);
        chk("rst_ov",     {31'h0, ov0}, 32'h0);
        chk("rst_ec",     {24'h0, ec0}, 32'h0);
        chk("rst_wr1",    {31'h0, wr1}, 32'h0);
        rst_n = 1'b1;
        repeat (3) cyc(8'h00, 1'b1, 1'b0, 1'b0);

        // ---------------- single word ----------------
        wr_base = wr0_cnt;
        cyc(8'hA1, 1'b0, 1'b0, 1'b0);
        cyc(8'hB2, 1'b1, 1'b0, 1'b0);
        cyc(8'hC3, 1'b0, 1'b0, 1'b0);
        chk("w1_wr_c2",   {31'h0, wr0}, 32'h0);
        cyc(8'hD4, 1'b1, 1'b0, 1'b0);
        chk("w1_wr_c3",   {31'h0, wr0}, 32'h0);
        cyc(8'hD4, 1'b1, 1'b0, 1'b0);
        chk("w1_wr_c4",   {31'h0, wr0}, 32'h1);
        chk("w1_data",    data0, 32'hA1B2C3D4);
        repeat (6) cyc(8'hD4, 1'b1, 1'b0, 1'b0);
        chk("w1_wr_count", wr0_cnt - wr_base, 32'd1);
        chk("w1_data_hold", data0, 32'hA1B2C3D4);

        // ---------------- back-to-back words, both latencies ----------------
        fe_base = fe0_cnt;
        wr_base = fe1_cnt;
        cyc(8'h00, 1'b0, 1'b0, 1'b0);
        cyc(8'h11, 1'b1, 1'b0, 1'b0);
        cyc(8'h22, 1'b0, 1'b0, 1'b0);
        cyc(8'h33, 1'b1, 1'b0, 1'b0);
        cyc(8'hFF, 1'b0, 1'b0, 1'b0);      // C4
        chk("b2b_wr0_c4",  {31'h0, wr0}, 32'h1);
        chk("b2b_data0_a", data0, 32'h00112233);
        chk("b2b_wr1_c4",  {31'h0, wr1}, 32'h0);
        cyc(8'hEE, 1'b1, 1'b0, 1'b0);      // C5
        chk("b2b_wr0_c5",  {31'h0, wr0}, 32'h0);
        chk("b2b_wr1_c5",  {31'h0, wr1}, 32'h1);
        chk("b2b_data1_a", data1, 32'h00112233);
        cyc(8'hDD, 1'b0, 1'b0, 1'b0);      // C6
        cyc(8'hCC, 1'b1, 1'b0, 1'b0);      // C7
        chk("b2b_wr0_c7",  {31'h0, wr0}, 32'h0);
        cyc(8'hCC, 1'b1, 1'b0, 1'b0);      // C8
        chk("b2b_wr0_c8",  {31'h0, wr0}, 32'h1);
        chk("b2b_data0_b", data0, 32'hFFEEDDCC);
        chk("b2b_wr1_c8",  {31'h0, wr1}, 32'h0);
        cyc(8'hCC, 1'b1, 1'b0, 1'b0);      // C9
        chk("b2b_wr1_c9",  {31'h0, wr1}, 32'h1);
        chk("b2b_data1_b", data1, 32'hFFEEDDCC);
        cyc(8'hCC, 1'b1, 1'b0, 1'b0);
        chk("b2b_fe0_none", fe0_cnt - fe_base, 32'd0);
        chk("b2b_fe1_none", fe1_cnt - wr_base, 32'd0);

        // ---------------- overflow and clear ----------------
        wr_base = wr0_cnt;
        cyc(8'h12, 1'b0, 1'b1, 1'b0);
        cyc(8'h34, 1'b1, 1'b1, 1'b0);
        cyc(8'h56, 1'b0, 1'b1, 1'b0);
        cyc(8'h78, 1'b1, 1'b1, 1'b0);
        chk("ovf_pre",     {31'h0, ov0}, 32'h0);
        cyc(8'h78, 1'b1, 1'b1, 1'b0);      // C4
        chk("ovf_wr",      {31'h0, wr0}, 32'h0);
        chk("ovf_flag",    {31'h0, ov0}, 32'h1);
        chk("ovf_ec",      {24'h0, ec0}, 32'd1);
        chk("ovf_data",    data0, 32'hFFEEDDCC);
        cyc(8'h78, 1'b1, 1'b0, 1'b1);      // clr sampled at end of this cycle
        chk("ovf_sticky",  {31'h0, ov0}, 32'h1);
        cyc(8'h78, 1'b1, 1'b0, 1'b0);
        chk("clr_ov",      {31'h0, ov0}, 32'h0);
        chk("clr_ec",      {24'h0, ec0}, 32'd0);
        chk("ovf_wr_count", wr0_cnt - wr_base, 32'd0);

        // ---------------- framing error with resync ----------------
        wr_base = wr0_cnt;
        fe_base = fe0_cnt;
        cyc(8'h11, 1'b0, 1'b0, 1'b0);      // C0
        cyc(8'h22, 1'b1, 1'b0, 1'b0);      // C1
        cyc(8'h33, 1'b0, 1'b0, 1'b0);      // C2
        cyc(8'h44, 1'b0, 1'b0, 1'b0);      // C3: phase error, new byte0
        chk("fe_none_c3",  {31'h0, fe0}, 32'h0);
        cyc(8'h55, 1'b1, 1'b0, 1'b0);      // C4
        chk("fe_pulse",    {31'h0, fe0}, 32'h1);
        chk("fe_ec",       {24'h0, ec0}, 32'd1);
        cyc(8'h66, 1'b0, 1'b0, 1'b0);      // C5
        chk("fe_one_cycle", {31'h0, fe0}, 32'h0);
        cyc(8'h77, 1'b1, 1'b0, 1'b0);      // C6
        cyc(8'h77, 1'b1, 1'b0, 1'b0);      // C7
        chk("fe_wr",       {31'h0, wr0}, 32'h1);
        chk("fe_data",     data0, 32'h44556677);
        repeat (4) cyc(8'h77, 1'b1, 1'b0, 1'b0);
        chk("fe_wr_count", wr0_cnt - wr_base, 32'd1);
        chk("fe_count",    fe0_cnt - fe_base, 32'd1);

        // ---------------- reset mid-word ----------------
        cyc(8'h01, 1'b0, 1'b0, 1'b0);
        cyc(8'h02, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        rx = 8'h00; shakehand = 1'b1;
        @(negedge clk);
        chk("mid_rst_data", data0, 32'h0);
        chk("mid_rst_wr",   {31'h0, wr0}, 32'h0);
        chk("mid_rst_fe",   {31'h0, fe0}, 32'h0);
        chk("mid_rst_ov",   {31'h0, ov0}, 32'h0);
        chk("mid_rst_ec",   {24'h0, ec0}, 32'd0);
        chk("mid_rst_data1", data1, 32'h0);
        rst_n = 1'b1;
        wr_base = wr0_cnt;
        fe_base = fe0_cnt;
        cyc(8'h00, 1'b1, 1'b0, 1'b0);
        cyc(8'hCA, 1'b0, 1'b0, 1'b0);
        cyc(8'hFE, 1'b1, 1'b0, 1'b0);
        cyc(8'hBA, 1'b0, 1'b0, 1'b0);
        cyc(8'hBE, 1'b1, 1'b0, 1'b0);
        cyc(8'hBE, 1'b1, 1'b0, 1'b0);
        chk("mid_rst_wr_c4", {31'h0, wr0}, 32'h1);
        chk("mid_rst_word",  data0, 32'hCAFEBABE);
        repeat (4) cyc(8'hBE, 1'b1, 1'b0, 1'b0);
        chk("mid_rst_wr_count", wr0_cnt - wr_base, 32'd1);
        chk("mid_rst_no_fe",    fe0_cnt - fe_base, 32'd0);

        // ---------------- error counter saturation ----------------
        // First phase-0 byte starts a word; each following one is a framing error
        repeat (301) cyc(8'h5A, 1'b0, 1'b0, 1'b0);
        cyc(8'h5A, 1'b1, 1'b0, 1'b0);      // valid byte1, leaves the FSM in B2
        chk("sat_ec",      {24'h0, ec0}, 32'd255);
        cyc(8'h5A, 1'b1, 1'b0, 1'b1);      // phase error in B2 together with clr
        cyc(8'h5A, 1'b1, 1'b0, 1'b0);
        chk("sat_clr_fe",  {31'h0, fe0}, 32'h1);
        chk("sat_clr_ec",  {24'h0, ec0}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Absolute time limit in case the stimulus ever stalls
    initial begin
        #200000;
        $display("FAIL timeout observed=stalled expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/aes_byte_rx.md
# aes_byte_rx

Byte-to-word deserializer on the receive side of the chip's 8-bit port, directly downstream of the port byte transmitter. It samples the transmitter's `tx` byte bus and its `shakehand` phase line, reassembles each group of four bytes (MSB first) into a 32-bit word, and pushes the word into the input FIFO that feeds the AES core. It also detects framing errors, resynchronises on them, reports FIFO overflow, and keeps an error counter.

## Interface
- `IN_REG`, 1: 1 registers `rx`/`shakehand` once before decoding (+1 cycle latency); 0 decodes the pins directly.
- `clk` input 1: single clock; all logic on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `rx` input 8: byte bus driven by the transmitter's `tx`.
- `shakehand` input 1: phase line. Per word it carries 0,1,0,1 on bytes 0..3. It idles at 1.
- `full` input 1: downstream FIFO full.
- `clr` input 1: synchronous clear of `overflow` and `err_cnt`.
- `data` output 32: assembled word, byte0 in [31:24] through byte3 in [7:0].
- `wr` output 1: one-cycle FIFO write strobe. `data` is valid in the same cycle.
- `frame_err` output 1: one-cycle pulse per framing error.
- `overflow` output 1: sticky. Set when a completed word is dropped because `full`=1.
- `err_cnt` output 8: saturating count of framing errors plus dropped words.

## Operation
- Reset values:
  - `data`=0, `wr`=0, `frame_err`=0, `overflow`=0, `err_cnt`=0.
  - State IDLE. Partial word cleared.
  - Input registers: `rx`=0, `shakehand`=1, so reset never produces a false byte0.
- Decoding uses the sampled byte b and sampled phase s (pins, or input register when `IN_REG`=1).
- States: IDLE, B1, B2, B3. Each state records the index of the next expected byte.
- IDLE:
  - s=0: capture b into [31:24], go to B1.
  - s=1: stay in IDLE. Idle repeats of the last byte are ignored.
- B1 expects s=1 and captures [23:16]. B2 expects s=0 and captures [15:8].
- B3 expects s=1 and captures [7:0]. The word is then complete and the state returns to IDLE.
- Back-to-back words: if s=0 in the cycle after byte3, that byte is byte0 of the next word. There is no idle gap.
- Framing error (s differs from the expected phase in B1, B2 or B3):
  - Pulse `frame_err`. Increment `err_cnt`. Discard the partial word.
  - If s=0, treat b as a new byte0 and go to B1. Otherwise go to IDLE.
- Word completion:
  - If `full`=0: `data` gets the word and `wr`=1 for one cycle.
  - If `full`=1: the word is dropped, `wr` stays 0, `overflow` is set, `err_cnt` is incremented.
- `data` holds its last written value while `wr`=0.
- `err_cnt` saturates at 255. A framing error and a drop never occur on the same edge.
- `clr`:
  - Clears `overflow` and `err_cnt`.
  - If an error or drop event occurs on the same edge, the event wins: `overflow` ends at 1 for a drop, and `err_cnt` ends at 1.
- `clr` does not affect the state machine, `data` or `wr`.
- Reset mid-word discards the partial word with no `wr` and no error.

## Timing
- Cycle numbering: byte k is on the pins during cycle Ck.
- `IN_REG`=0: byte3 is captured at the end of C3. `wr` and `data` are valid in C4. Latency is 1 cycle after byte3.
- `IN_REG`=1: everything shifts one cycle later. `wr` is valid in C5.
- Sustained throughput is one word per 4 cycles. `wr` pulses are then exactly 4 cycles apart.
- `full` is sampled on the same edge that would assert `wr`. It is a combinational FIFO status and needs no lookahead.
- `frame_err` and the `err_cnt` increment appear one cycle after the offending byte is decoded. This is the same relative timing as `wr`.
- All outputs are registered.

## Test plan
- Single word 0xA1B2C3D4 (`IN_REG`=0): `shakehand` 0,1,0,1, then idle at 1 with `rx` held at 0xD4. Required: one `wr` pulse in C4 with `data`=0xA1B2C3D4, then no further `wr` during idle.
- Back-to-back words 0x00112233 and 0xFFEEDDCC: required `wr` pulses in C4 and C8 with the correct data, no `frame_err`. Repeat with `IN_REG`=1: pulses move to C5 and C9.
- Overflow: `full`=1 while 0x12345678 completes. Required: no `wr`, `overflow`=1, `err_cnt`=1. Then `clr`=1 for one cycle: both clear.
- Framing error with resync: phases 0,1,0,0,1,0,1 carrying bytes 11,22,33,44,55,66,77. Required: `frame_err` pulses after the 4th byte, `err_cnt`=1, then exactly one `wr` with `data`=0x44556677.
- Reset mid-word: assert `rst_n`=0 after byte1 is sent, then release and send 0xCAFEBABE. Required: all outputs are at their reset values during reset, and the only `wr` carries 0xCAFEBABE.
- Saturation: force 300 framing errors (phases 0,0 repeated). Required: `err_cnt`=255. A `clr` on the same edge as an error leaves `err_cnt`=1.
